// File: rtl/time_sync_engine.sv
// Two-way time-sync engine: an initiator that runs REQ/RESP exchanges and
// collects {t0,t1,t2,t3}, plus a responder that answers inbound REQs.
module time_sync_engine #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] local_time,
  input  logic        start_i,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [63:0] tx_msg_o,
  input  logic        rx_valid_i,
  input  logic [63:0] rx_msg_i,
  output logic        update_time_valid_o,
  output logic [63:0] update_time_o,
  output logic        busy_o,
  output logic [7:0]  timeout_cnt_o,
  output logic [7:0]  drop_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ_TX,
    WAIT_RESP
  } state_t;

  localparam logic [1:0]  TYPE_REQ     = 2'b01;
  localparam logic [1:0]  TYPE_RESP    = 2'b10;
  localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_CYC - 16'd1;

  state_t      state;
  logic [3:0]  seq;
  logic [15:0] t0;
  logic [15:0] wait_cnt;
  logic        resp_pending;
  logic [3:0]  resp_seq;
  logic [15:0] resp_t1;
  logic        tx_is_resp;

  logic [1:0]  rx_type;
  logic [3:0]  rx_seq;
  logic        rx_req;
  logic        rx_resp;
  logic        rx_bad;
  logic        resp_match;
  logic        resp_shown;
  logic        req_accept;
  logic        load_resp;
  logic        load_req;
  logic [3:0]  eff_seq;
  logic [15:0] eff_t1;
  logic        drop_evt;
  logic        tx_hs;
  logic        rx_unused;

  always_comb begin
    rx_type    = rx_msg_i[63:62];
    rx_seq     = rx_msg_i[61:58];
    rx_unused  = ^rx_msg_i[57:32];
    rx_req     = rx_valid_i && (rx_type == TYPE_REQ);
    rx_resp    = rx_valid_i && (rx_type == TYPE_RESP);
    rx_bad     = rx_valid_i && ((rx_type == 2'b00) || (rx_type == 2'b11));
    resp_match = rx_resp && (state == WAIT_RESP) && (rx_seq == seq);
    resp_shown = tx_valid_o && tx_is_resp;
    req_accept = rx_req && !resp_shown;
    tx_hs      = tx_valid_o && tx_ready_i;
    load_resp  = !tx_valid_o && resp_pending;
    load_req   = !tx_valid_o && !resp_pending && (state == REQ_TX);
    // A REQ arriving in the very cycle the RESP is loaded still overwrites it,
    // so the loaded message takes the incoming seq/t1 directly.
    eff_seq    = req_accept ? rx_seq     : resp_seq;
    eff_t1     = req_accept ? local_time : resp_t1;
    drop_evt   = (rx_req && resp_pending) || (rx_resp && !resp_match) || rx_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      seq                 <= '0;
      t0                  <= '0;
      wait_cnt            <= '0;
      resp_pending        <= 1'b0;
      resp_seq            <= '0;
      resp_t1             <= '0;
      tx_is_resp          <= 1'b0;
      tx_valid_o          <= 1'b0;
      tx_msg_o            <= '0;
      update_time_valid_o <= 1'b0;
      update_time_o       <= '0;
      busy_o              <= 1'b0;
      timeout_cnt_o       <= '0;
      drop_cnt_o          <= '0;
    end else begin
      update_time_valid_o <= 1'b0;

      if (tx_hs && tx_is_resp)
        resp_pending <= 1'b0;
      if (req_accept) begin
        resp_pending <= 1'b1;
        resp_seq     <= rx_seq;
        resp_t1      <= local_time;
      end

      if (tx_hs) begin
        tx_valid_o <= 1'b0;
      end else if (load_resp) begin
        tx_valid_o <= 1'b1;
        tx_is_resp <= 1'b1;
        tx_msg_o   <= {TYPE_RESP, eff_seq, 26'd0, eff_t1, local_time};
      end else if (load_req) begin
        tx_valid_o <= 1'b1;
        tx_is_resp <= 1'b0;
        tx_msg_o   <= {TYPE_REQ, seq, 26'd0, local_time, 16'd0};
        t0         <= local_time;
      end

      if (drop_evt && (drop_cnt_o != 8'hFF))
        drop_cnt_o <= drop_cnt_o + 8'd1;

      case (state)
        IDLE: begin
          if (start_i) begin
            state  <= REQ_TX;
            seq    <= seq + 4'd1;
            busy_o <= 1'b1;
          end
        end
        REQ_TX: begin
          if (tx_hs && !tx_is_resp) begin
            state    <= WAIT_RESP;
            wait_cnt <= '0;
          end
        end
        WAIT_RESP: begin
          if (resp_match) begin
            state               <= IDLE;
            busy_o              <= 1'b0;
            update_time_valid_o <= 1'b1;
            update_time_o       <= {t0, rx_msg_i[31:16], rx_msg_i[15:0], local_time};
          end else if (wait_cnt == TIMEOUT_LAST) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            if (timeout_cnt_o != 8'hFF)
              timeout_cnt_o <= timeout_cnt_o + 8'd1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
